// File: rtl/memory_stage_pkg.sv
// Shared types and constants for the memory pipeline stage.
package memory_stage_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  // Doubleword accesses must have these low address bits clear.
  localparam int unsigned ALIGN_BITS = 3;

endpackage

// File: rtl/memory_stage_ex_mem_reg.sv
// EX/MEM pipeline register: loads the execute bundle when enabled, holds otherwise.
module ex_mem_reg #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         valid_E,
  input  logic         Branch_E,
  input  logic         UncondBranch_E,
  input  logic         MemRead_E,
  input  logic         MemWrite_E,
  input  logic         zero_E,
  input  logic [N-1:0] PCBranch_E,
  input  logic [N-1:0] aluResult_E,
  input  logic [N-1:0] writeData_E,
  output logic         valid_M,
  output logic         Branch_M,
  output logic         UncondBranch_M,
  output logic         MemRead_M,
  output logic         MemWrite_M,
  output logic         zero_M,
  output logic [N-1:0] PCBranch_M,
  output logic [N-1:0] aluResult_M,
  output logic [N-1:0] writeData_M
);

  logic         valid_q, valid_d;
  logic         branch_q, branch_d;
  logic         uncond_q, uncond_d;
  logic         mem_read_q, mem_read_d;
  logic         mem_write_q, mem_write_d;
  logic         zero_q, zero_d;
  logic [N-1:0] pc_branch_q, pc_branch_d;
  logic [N-1:0] alu_result_q, alu_result_d;
  logic [N-1:0] write_data_q, write_data_d;

  // Next-state: take the execute bundle when enabled, otherwise hold.
  always_comb begin
    valid_d      = valid_q;
    branch_d     = branch_q;
    uncond_d     = uncond_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    zero_d       = zero_q;
    pc_branch_d  = pc_branch_q;
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    if (en) begin
      valid_d      = valid_E;
      branch_d     = Branch_E;
      uncond_d     = UncondBranch_E;
      mem_read_d   = MemRead_E;
      mem_write_d  = MemWrite_E;
      zero_d       = zero_E;
      pc_branch_d  = PCBranch_E;
      alu_result_d = aluResult_E;
      write_data_d = writeData_E;
    end
  end

  // Register bank with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      branch_q     <= 1'b0;
      uncond_q     <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      zero_q       <= 1'b0;
      pc_branch_q  <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
    end else begin
      valid_q      <= valid_d;
      branch_q     <= branch_d;
      uncond_q     <= uncond_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      zero_q       <= zero_d;
      pc_branch_q  <= pc_branch_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
    end
  end

  assign valid_M        = valid_q;
  assign Branch_M       = branch_q;
  assign UncondBranch_M = uncond_q;
  assign MemRead_M      = mem_read_q;
  assign MemWrite_M     = mem_write_q;
  assign zero_M         = zero_q;
  assign PCBranch_M     = pc_branch_q;
  assign aluResult_M    = alu_result_q;
  assign writeData_M    = write_data_q;

endmodule

// File: rtl/memory_stage.sv
// Memory stage: EX/MEM register, branch resolution and req/ack data-memory access.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_E,
  input  logic         Branch_E,
  input  logic         UncondBranch_E,
  input  logic         MemRead_E,
  input  logic         MemWrite_E,
  input  logic [N-1:0] PCBranch_E,
  input  logic [N-1:0] aluResult_E,
  input  logic [N-1:0] writeData_E,
  input  logic         zero_E,
  output logic         dm_req,
  output logic         dm_we,
  output logic [N-1:0] dm_addr,
  output logic [N-1:0] dm_wdata,
  input  logic         dm_ack,
  input  logic [N-1:0] dm_rdata,
  output logic         valid_M,
  output logic         PCSrc_M,
  output logic [N-1:0] PCBranch_M,
  output logic [N-1:0] aluResult_M,
  output logic [N-1:0] readData_M,
  output logic         misalign_M,
  output logic         stall_M
);

  logic         branch_m, uncond_m, mem_read_m, mem_write_m, zero_m;
  logic [N-1:0] write_data_m;
  logic         mem_access, aligned, mem_op;

  mem_state_t   state_q, state_d;
  logic [N-1:0] read_data_q, read_data_d;

  ex_mem_reg #(.N(N)) u_ex_mem_reg (
    .clk            (clk),
    .reset          (reset),
    .en             (~stall_M),
    .valid_E        (valid_E),
    .Branch_E       (Branch_E),
    .UncondBranch_E (UncondBranch_E),
    .MemRead_E      (MemRead_E),
    .MemWrite_E     (MemWrite_E),
    .zero_E         (zero_E),
    .PCBranch_E     (PCBranch_E),
    .aluResult_E    (aluResult_E),
    .writeData_E    (writeData_E),
    .valid_M        (valid_M),
    .Branch_M       (branch_m),
    .UncondBranch_M (uncond_m),
    .MemRead_M      (mem_read_m),
    .MemWrite_M     (mem_write_m),
    .zero_M         (zero_m),
    .PCBranch_M     (PCBranch_M),
    .aluResult_M    (aluResult_M),
    .writeData_M    (write_data_m)
  );

  assign mem_access = mem_read_m | mem_write_m;
  assign aligned    = (aluResult_M[ALIGN_BITS-1:0] == '0);
  assign mem_op     = valid_M & mem_access & aligned;
  assign misalign_M = valid_M & mem_access & ~aligned;

  // Access FSM next-state, request drivers and load-data capture.
  // Read-and-write together is a write, so load capture keys only on ~MemWrite.
  always_comb begin
    state_d     = state_q;
    read_data_d = read_data_q;
    stall_M     = 1'b0;
    dm_req      = 1'b0;
    dm_we       = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          stall_M = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        stall_M = 1'b1;
        dm_req  = 1'b1;
        dm_we   = mem_write_m;
        if (dm_ack) begin
          if (!mem_write_m) read_data_d = dm_rdata;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state and load-data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      read_data_q <= read_data_d;
    end
  end

  assign dm_addr    = dm_req ? aluResult_M  : '0;
  assign dm_wdata   = dm_req ? write_data_m : '0;
  assign readData_M = read_data_q;
  assign PCSrc_M    = valid_M & (uncond_m | (branch_m & zero_m)) & ~stall_M;

endmodule
